// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and CPU control-field layout for the generic pipeline stage register.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int ID_EX_CTRL_W  = 16;
  localparam int REG_WRITE_BIT = 0;
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 2;
  localparam int BRANCH_BIT    = 3;
  localparam int JUMP_BIT      = 4;

  function automatic logic [ID_EX_CTRL_W-1:0] ctrl_bit(input int idx);
    logic [ID_EX_CTRL_W-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Bits that must not take effect for a squashed instruction, per stage boundary
  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_KILL_MASK =
    ctrl_bit(REG_WRITE_BIT) | ctrl_bit(MEM_READ_BIT) | ctrl_bit(MEM_WRITE_BIT);
  localparam logic [ID_EX_CTRL_W-1:0] EX_MEM_KILL_MASK =
    ctrl_bit(REG_WRITE_BIT) | ctrl_bit(MEM_READ_BIT) | ctrl_bit(MEM_WRITE_BIT);
  localparam logic [ID_EX_CTRL_W-1:0] MEM_WB_KILL_MASK = ctrl_bit(REG_WRITE_BIT);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying a payload and a control vector.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One {valid,data,ctrl} pipeline entry; load has priority over clear, mask zeroes ctrl bits.
module pipe_stage_reg_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [CTRL_W-1:0] mask_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
      ctrl_d  = ctrl_i & ~mask_i;
    end else if (clear_i) begin
      // payload is left in place; only the masked control bits are scrubbed
      valid_d = 1'b0;
      ctrl_d  = ctrl_q & ~mask_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional skid entry,
// flush as drop or bubble, saturating stall counter.
//   state    | meaning
//   ST_EMPTY | no entry held, occupancy 0
//   ST_ONE   | main entry valid, occupancy 1
//   ST_FULL  | main + skid valid, occupancy 2, input blocked (SKID=1 only)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK  = {CTRL_W{1'b1}},
  parameter int                SKID       = 1,
  parameter int                FLUSH_MODE = 0,
  parameter int                CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  input  logic             flush_i,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  pipe_state_e       state_q, state_d;
  logic              in_ready, acc_in, acc_out;
  logic              main_load, main_clear, main_from_skid, main_vld_in;
  logic [CTRL_W-1:0] main_mask;
  logic              main_valid;
  logic [DATA_W-1:0] main_data, main_data_in;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_in;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign acc_in  = in_if.valid & in_ready;
  assign acc_out = main_valid & out_if.ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    main_vld_in    = 1'b1;
    main_mask      = '0;
    if (flush_i) begin
      main_mask = KILL_MASK;
      if (FLUSH_MODE == 0) begin
        main_clear = 1'b1;
        state_d    = ST_EMPTY;
      end else begin
        main_load   = 1'b1;
        main_vld_in = in_if.valid;
        state_d     = in_if.valid ? ST_ONE : ST_EMPTY;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_in) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if ((SKID != 0) && acc_in && !acc_out) begin
            state_d = ST_FULL;
          end else if (acc_in) begin
            main_load = 1'b1;
          end else if (acc_out) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (acc_out) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_data_in = main_from_skid ? skid_data : in_if.data;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_if.ctrl;

  pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .valid_i (main_vld_in),
    .data_i  (main_data_in),
    .ctrl_i  (main_ctrl_in),
    .mask_i  (main_mask),
    .valid_o (main_valid),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q;
    logic skid_load, skid_clear;

    assign skid_load  = ~flush_i & (state_q == ST_ONE) & acc_in & ~acc_out;
    assign skid_clear = flush_i | ((state_q == ST_FULL) & acc_out);

    always_ff @(posedge clk) begin
      if (!reset) begin
        in_ready_q <= 1'b0;
      end else begin
        in_ready_q <= (state_d != ST_FULL);
      end
    end

    // A flush always swallows the incoming beat, even from the FULL state
    assign in_ready = in_ready_q | (flush_i & reset);

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .valid_i (1'b1),
      .data_i  (in_if.data),
      .ctrl_i  (in_if.ctrl),
      .mask_i  ({CTRL_W{1'b0}}),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
    );
  end else begin : g_no_skid
    assign in_ready   = ~main_valid | out_if.ready | flush_i;
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_ctrl  = '0;
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_if.ready && !flush_i && !(&stall_q)) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = main_ctrl;
  assign occupancy_o  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt_o  = stall_q;

endmodule
